division: RTL and testbench
===========================

Name: division

Overview:
- Iterative unsigned integer divider for the i16 ALU; the inverse of the combinational Multiplication block.
- Takes dividend A and divisor B and produces quotient R1 and remainder R2 using restoring division, one quotient bit per clock.
- Sits beside Multiplication in src/ALU. The ALU control holds the instruction with Start/Busy/Done.

Parameters:
- l, 16, operand/result width in bits (legal range 2..16).

Ports:
- CLK  input  1  clock, all state updates on the rising edge.
- RST  input  1  reset, synchronous and active-high.
- Start  input  1  request a division; sampled on a rising edge.
- A  input  l  dividend, unsigned; sampled only on an accepted Start.
- B  input  l  divisor, unsigned; sampled only on an accepted Start.
- Busy  output  1  high while a division is in progress.
- Done  output  1  one-cycle pulse: R1/R2 are valid.
- R1  output  l  quotient.
- R2  output  l  remainder.

Behaviour:
- Reset
  - RST high at an edge returns the block to IDLE.
  - Busy=0, Done=0, R1=0, R2=0.
  - Internal dividend/remainder/divisor registers and the counter are cleared.
  - Reset takes priority over Start and over an in-flight division; a division in progress is abandoned and no Done is produced.
- States: IDLE, RUN, DONE.
- IDLE or DONE, Start=1 at edge E0 (accepted Start)
  - Latch A into the working dividend and B into the divisor.
  - Clear the partial remainder (l+1 bits).
  - Load the counter with l.
  - Busy=1, Done=0, go to RUN.
- RUN, each edge
  - Shift {rem, dvd} left by 1.
  - If shifted rem >= divisor: rem -= divisor and shift in quotient bit 1; else shift in 0.
  - Decrement the counter.
- Last iteration (edge El, where E1..El are the l RUN edges)
  - R1 = quotient, R2 = low l bits of the remainder.
  - Busy=0, Done=1, go to DONE.
- Latency
  - Done is high in the cycle following edge E(l), i.e. l+1 edges after the Start edge.
  - Latency is fixed and data-independent.
- DONE
  - Done returns to 0 at the next edge unless a new Start is accepted at that edge, which is handled as from IDLE.
  - Without a new Start, the next state is IDLE.
- Hold
  - R1/R2 keep their last result until the next completion or reset.
  - They are not modified during RUN; intermediate values live only in internal registers.
- Start while Busy: ignored; the operands are not sampled and the current division is undisturbed.
- Divide by zero
  - No special case. The algorithm naturally yields R1 = all ones (2^l - 1) and R2 = A, matching the RISC-V DIVU/REMU result.
  - Latency is the same l+1 edges.
- Width rules
  - The partial remainder is l+1 bits so that the compare/subtract never overflows.
  - Quotient and remainder are exactly l bits.
  - Invariant on completion: A == R1*B + R2 and R2 < B (when B != 0).
- Counter
  - Width is clog2(l)+1.
  - The completion condition is the counter reaching 1 during RUN, so exactly l RUN iterations occur.

Test Plan:
- l=3, A=7, B=2, Start one cycle -> Busy high for 3 edges; Done pulse at edge 4 after Start; R1=3, R2=1.
- l=16, A=100, B=7 -> R1=14, R2=2.
- l=16, A=5, B=9 -> R1=0, R2=5.
- l=16, A=65535, B=1 -> R1=65535, R2=0.
- l=16, A=1234, B=0 -> R1=65535, R2=1234, same latency as a normal division.
- l=16, Start 100/7 and then:
  - Pulse Start with A=9, B=3 at RUN iteration 5 -> ignored; result R1=14, R2=2.
  - Start 50/5 issued in the Done cycle -> accepted; back-to-back result R1=10, R2=0.
  - Assert RST at iteration 8 of a new division -> next cycle Busy=0, Done=0, R1=0, R2=0, and no Done follows.

Source files
------------

// File: rtl/division.sv
// division: iterative unsigned restoring divider for the i16 ALU.
// Produces one quotient bit per clock; a division takes l RUN cycles after
// the accepting Start edge, and Done pulses for one cycle with the result.
//
// Ports:
//   CLK   - clock, all state updates on the rising edge
//   RST   - synchronous, active-high reset
//   Start - division request, accepted only when not Busy
//   A     - dividend (unsigned, l bits), sampled on an accepted Start
//   B     - divisor  (unsigned, l bits), sampled on an accepted Start
//   Busy  - high while a division is in progress
//   Done  - one-cycle pulse, R1/R2 hold a fresh result
//   R1    - quotient
//   R2    - remainder
//
// A zero divisor is not special-cased: the algorithm yields R1 = all ones
// and R2 = A, which matches RISC-V DIVU/REMU.
module division #(
  parameter int l = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         Start,
  input  logic [l-1:0] A,
  input  logic [l-1:0] B,
  output logic         Busy,
  output logic         Done,
  output logic [l-1:0] R1,
  output logic [l-1:0] R2
);

  localparam int CW = $clog2(l) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_r;
  state_t state_next_s;

  // Partial remainder carries one extra bit so compare/subtract never overflows.
  logic [l:0]    rem_r;
  logic [l-1:0]  dvd_r;   // shifts dividend bits out, quotient bits in
  logic [l-1:0]  dvs_r;
  logic [CW-1:0] cnt_r;

  logic          load_s;
  logic          step_s;
  logic          finish_s;

  logic [l:0]    shifted_s;
  logic [l:0]    diff_s;
  logic [l:0]    rem_next_s;
  logic [l-1:0]  dvd_next_s;
  logic          qbit_s;

  // One restoring-division iteration on the current working registers.
  always_comb begin
    shifted_s  = {rem_r[l-1:0], dvd_r[l-1]};
    diff_s     = shifted_s - {1'b0, dvs_r};
    qbit_s     = (shifted_s >= {1'b0, dvs_r});
    if (qbit_s) begin
      rem_next_s = diff_s;
    end else begin
      rem_next_s = shifted_s;
    end
    dvd_next_s = {dvd_r[l-2:0], qbit_s};
  end

  // Next-state and control decode.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    step_s       = 1'b0;
    finish_s     = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        // A new Start in the Done cycle is accepted exactly as from IDLE.
        if (Start) begin
          load_s       = 1'b1;
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        // Start is ignored here; the in-flight division is undisturbed.
        step_s = 1'b1;
        if (cnt_r == CW'(1)) begin
          finish_s     = 1'b1;
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Working registers: load operands on accept, iterate while running.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rem_r <= {(l+1){1'b0}};
      dvd_r <= {l{1'b0}};
      dvs_r <= {l{1'b0}};
      cnt_r <= {CW{1'b0}};
    end else if (load_s) begin
      rem_r <= {(l+1){1'b0}};
      dvd_r <= A;
      dvs_r <= B;
      cnt_r <= CW'(l);
    end else if (step_s) begin
      rem_r <= rem_next_s;
      dvd_r <= dvd_next_s;
      cnt_r <= cnt_r - CW'(1);
    end else begin
      rem_r <= rem_r;
      dvd_r <= dvd_r;
      dvs_r <= dvs_r;
      cnt_r <= cnt_r;
    end
  end

  // Registered outputs; R1/R2 change only when a division completes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      Busy <= 1'b0;
      Done <= 1'b0;
      R1   <= {l{1'b0}};
      R2   <= {l{1'b0}};
    end else begin
      Busy <= load_s | (step_s & ~finish_s);
      Done <= finish_s;
      if (finish_s) begin
        R1 <= dvd_next_s;
        R2 <= rem_next_s[l-1:0];
      end else begin
        R1 <= R1;
        R2 <= R2;
      end
    end
  end

endmodule

// File: tb/tb_division.sv
// Self-checking bench for division: an l=16 and an l=3 instance, checked
// against an arithmetic reference (a/b, a%b, divide-by-zero convention).
module tb_division;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST;
  logic        start16, start3;
  logic [15:0] a16, b16;
  logic [2:0]  a3, b3;
  logic        busy16, done16, busy3, done3;
  logic [15:0] r1_16, r2_16;
  logic [2:0]  r1_3, r2_3;

  division #(.l(16)) dut16 (
    .CLK(CLK), .RST(RST), .Start(start16), .A(a16), .B(b16),
    .Busy(busy16), .Done(done16), .R1(r1_16), .R2(r2_16)
  );

  division #(.l(3)) dut3 (
    .CLK(CLK), .RST(RST), .Start(start3), .A(a3), .B(b3),
    .Busy(busy3), .Done(done3), .R1(r1_3), .R2(r2_3)
  );

  int          checks = 0;
  int          errors = 0;
  logic        cur3 = 1'b0;
  logic        obs_busy, obs_done;
  logic [15:0] obs_r1, obs_r2;
  logic [15:0] last16_r1, last16_r2, last3_r1, last3_r2;

  always_comb begin
    obs_busy = cur3 ? busy3 : busy16;
    obs_done = cur3 ? done3 : done16;
    obs_r1   = cur3 ? {13'd0, r1_3} : r1_16;
    obs_r2   = cur3 ? {13'd0, r2_3} : r2_16;
  end

  // Reference: unsigned division; divide by zero gives all ones and A.
  task automatic model(input int w, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] q, output logic [15:0] r);
    logic [15:0] mask;
    mask = (w == 16) ? 16'hFFFF : 16'h0007;
    if (b == 16'd0) begin
      q = mask;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  task automatic drive(input logic s, input logic [15:0] a, input logic [15:0] b);
    if (cur3) begin
      start3 = s; a3 = a[2:0]; b3 = b[2:0];
    end else begin
      start16 = s; a16 = a; b16 = b;
    end
  endtask

  // Issue one division and follow it to Done. Called at posedge+1.
  // inj: 0 none, 1 Start pulse 9/3 at RUN iteration 5, 2 RST at iteration 8.
  task automatic run(input int w, input logic [15:0] a, input logic [15:0] b,
                     input int inj, input string name);
    logic [15:0] eq, er, hq, hr;
    int          edges;
    bit          seen, aborted;
    cur3 = (w == 3);
    model(w, a, b, eq, er);
    hq = cur3 ? last3_r1 : last16_r1;
    hr = cur3 ? last3_r2 : last16_r2;
    drive(1'b1, a, b);
    @(posedge CLK); #1;
    drive(1'b0, 16'($urandom), 16'($urandom));
    checks++;
    if (obs_busy !== 1'b1 || obs_done !== 1'b0) begin
      errors++;
      $display("FAIL %s accept: busy=%b done=%b, expected busy=1 done=0", name, obs_busy, obs_done);
    end
    edges = 0; seen = 0; aborted = 0;
    while (!seen && !aborted && edges < 40) begin
      @(posedge CLK); #1;
      edges++;
      if (inj == 2 && edges == 8) begin
        RST = 1'b0;
        aborted = 1;
        checks++;
        if (obs_busy !== 1'b0 || obs_done !== 1'b0 || obs_r1 !== 16'd0 || obs_r2 !== 16'd0) begin
          errors++;
          $display("FAIL %s reset: busy=%b done=%b R1=%0d R2=%0d, expected all 0",
                   name, obs_busy, obs_done, obs_r1, obs_r2);
        end
      end else if (obs_done === 1'b1) begin
        seen = 1;
      end else begin
        checks++;
        if (obs_busy !== 1'b1 || obs_r1 !== hq || obs_r2 !== hr) begin
          errors++;
          $display("FAIL %s run_hold edge %0d: busy=%b R1=%0d R2=%0d, expected busy=1 R1=%0d R2=%0d",
                   name, edges, obs_busy, obs_r1, obs_r2, hq, hr);
        end
        if (inj == 1 && edges == 4) drive(1'b1, 16'd9, 16'd3);
        if (inj == 1 && edges == 5) drive(1'b0, 16'd0, 16'd0);
        if (inj == 2 && edges == 7) RST = 1'b1;
      end
    end
    if (aborted) begin
      last16_r1 = 16'd0; last16_r2 = 16'd0;
      last3_r1  = 16'd0; last3_r2  = 16'd0;
      seen = 0;
      repeat (24) begin
        @(posedge CLK); #1;
        if (obs_done === 1'b1 || obs_busy === 1'b1) seen = 1;
      end
      checks++;
      if (seen) begin
        errors++;
        $display("FAIL %s post_reset: Done/Busy seen after abandoned division, expected none", name);
      end
    end else begin
      checks++;
      if (!seen || edges != w) begin
        errors++;
        $display("FAIL %s latency: done_seen=%0d edges=%0d, expected done after %0d edges",
                 name, seen, edges, w);
      end
      checks++;
      if (obs_busy !== 1'b0 || obs_r1 !== eq || obs_r2 !== er) begin
        errors++;
        $display("FAIL %s result A=%0d B=%0d: busy=%b R1=%0d R2=%0d, expected busy=0 R1=%0d R2=%0d",
                 name, a, b, obs_busy, obs_r1, obs_r2, eq, er);
      end
      if (cur3) begin
        last3_r1 = eq; last3_r2 = er;
      end else begin
        last16_r1 = eq; last16_r2 = er;
      end
    end
  endtask

  // The cycle after Done: pulse gone, idle, result held.
  task automatic tail(input string name);
    logic [15:0] hq, hr;
    hq = cur3 ? last3_r1 : last16_r1;
    hr = cur3 ? last3_r2 : last16_r2;
    @(posedge CLK); #1;
    checks++;
    if (obs_done !== 1'b0 || obs_busy !== 1'b0 || obs_r1 !== hq || obs_r2 !== hr) begin
      errors++;
      $display("FAIL %s tail: done=%b busy=%b R1=%0d R2=%0d, expected done=0 busy=0 R1=%0d R2=%0d",
               name, obs_done, obs_busy, obs_r1, obs_r2, hq, hr);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    start16 = 1'b0; start3 = 1'b0;
    a16 = 16'd0; b16 = 16'd0; a3 = 3'd0; b3 = 3'd0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    last16_r1 = 16'd0; last16_r2 = 16'd0; last3_r1 = 16'd0; last3_r2 = 16'd0;
    checks++;
    if (busy16 !== 1'b0 || done16 !== 1'b0 || r1_16 !== 16'd0 || r2_16 !== 16'd0) begin
      errors++;
      $display("FAIL reset16: busy=%b done=%b R1=%0d R2=%0d, expected all 0", busy16, done16, r1_16, r2_16);
    end
    checks++;
    if (busy3 !== 1'b0 || done3 !== 1'b0 || r1_3 !== 3'd0 || r2_3 !== 3'd0) begin
      errors++;
      $display("FAIL reset3: busy=%b done=%b R1=%0d R2=%0d, expected all 0", busy3, done3, r1_3, r2_3);
    end
  endtask

  task automatic test_l3();
    run(3, 16'd7, 16'd2, 0, "l3_7_2");
    tail("l3_7_2");
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        run(3, 16'(a), 16'(b), 0, "l3_exhaustive");
      end
    end
    tail("l3_exhaustive");
  endtask

  task automatic test_directed();
    logic [15:0] da [5];
    logic [15:0] db [5];
    da = '{16'd100, 16'd5, 16'd65535, 16'd1234, 16'd65535};
    db = '{16'd7,   16'd9, 16'd1,     16'd0,    16'd65535};
    for (int i = 0; i < 5; i++) begin
      run(16, da[i], db[i], 0, "directed");
      tail("directed");
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b;
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0: b = 16'd0;
        1: b = 16'($urandom_range(1, 15));
        2: b = 16'($urandom_range(1, 255));
        default: b = 16'($urandom);
      endcase
      run(16, a, b, 0, "random");
      if (i % 4 == 0) tail("random");
    end
    tail("random");
  endtask

  task automatic test_start_while_busy();
    run(16, 16'd100, 16'd7, 1, "busy_ignore");
    tail("busy_ignore");
  endtask

  task automatic test_back_to_back();
    run(16, 16'd100, 16'd7, 0, "b2b_first");
    run(16, 16'd50, 16'd5, 0, "b2b_second");
    tail("b2b_second");
  endtask

  task automatic test_reset_midway();
    run(16, 16'd40000, 16'd123, 2, "rst_mid");
    run(16, 16'd300, 16'd11, 0, "after_rst");
    tail("after_rst");
  endtask

  initial begin
    RST = 1'b1;
    start16 = 1'b0; start3 = 1'b0;
    a16 = 16'd0; b16 = 16'd0; a3 = 3'd0; b3 = 3'd0;
    test_reset();
    test_l3();
    test_directed();
    test_random();
    test_start_while_busy();
    test_back_to_back();
    test_reset_midway();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
